reg_block: RTL and testbench

- General-purpose register file: 256 entries × 16 bits.
- Two independent combinational read ports (A, B) and one synchronous write port.
- Sits between instruction decode (supplies addresses) and the ALU / writeback path (consumes operands, supplies results).
- Read ports feed ALU operands A and B; the write port takes the writeback result.

---
 rtl/reg_block_pkg.sv | 11 +
 rtl/reg_block_if.sv | 22 ++
 rtl/reg_block_rdport.sv | 10 +
 rtl/reg_block.sv | 40 ++++
 tb/tb_reg_block.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/reg_block_pkg.sv
// Shared types and sizes for the 256 x 16 general-purpose register file.
package reg_block_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int NUM_RD = 2;

    typedef logic [ADDR_W-1:0]             addr_t;
    typedef logic [DATA_W-1:0]             data_t;
    typedef logic [DEPTH-1:0][DATA_W-1:0]  mem_t;
endpackage

// File: rtl/reg_block_if.sv
// Decode/ALU-facing bus of the register file: two read ports, one write port.
interface reg_block_if;
    import reg_block_pkg::*;

    addr_t Addr_Out_A;
    addr_t Addr_Out_B;
    addr_t Addr_In;
    data_t Data_In;
    logic  WE;
    data_t Data_Out_A;
    data_t Data_Out_B;

    modport master (
        output Addr_Out_A, Addr_Out_B, Addr_In, Data_In, WE,
        input  Data_Out_A, Data_Out_B
    );

    modport slave (
        input  Addr_Out_A, Addr_Out_B, Addr_In, Data_In, WE,
        output Data_Out_A, Data_Out_B
    );
endinterface

// File: rtl/reg_block_rdport.sv
// DEPTH:1 combinational read mux over the whole storage array.
module reg_block_rdport
    import reg_block_pkg::*;
(
    input  addr_t addr,
    input  mem_t  mem,
    output data_t data
);
    assign data = mem[addr];
endmodule

// File: rtl/reg_block.sv
// Register file top: write decode and storage, plus two combinational read ports.
module reg_block
    import reg_block_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    reg_block_if.slave  bus
);
    mem_t                    mem;
    logic                    wr_arm;
    addr_t [NUM_RD-1:0]      rd_addr;
    data_t [NUM_RD-1:0]      rd_data;

    // Armed on the falling edge so a rising edge that coincides with reset
    // release never writes, independent of event ordering at that edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) wr_arm <= 1'b0;
        else        wr_arm <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem <= '0;
        else if (bus.WE && wr_arm)
            mem[bus.Addr_In] <= bus.Data_In;
    end

    assign rd_addr = {bus.Addr_Out_B, bus.Addr_Out_A};

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        reg_block_rdport u_rd (
            .addr (rd_addr[i]),
            .mem  (mem),
            .data (rd_data[i])
        );
    end

    assign bus.Data_Out_A = rd_data[0];
    assign bus.Data_Out_B = rd_data[1];
endmodule

// File: tb/tb_reg_block.sv
// Bench for reg_block: directed cases plus random traffic against an array model.
module tb_reg_block;
    import reg_block_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    data_t model [DEPTH];

    reg_block_if bus ();

    reg_block dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input data_t got, input data_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input addr_t a, input addr_t b);
        bus.Addr_Out_A = a;
        bus.Addr_Out_B = b;
        #1;
        chk({tag, "_A"}, bus.Data_Out_A, model[a]);
        chk({tag, "_B"}, bus.Data_Out_B, model[b]);
    endtask

    task automatic wr(input addr_t a, input data_t d);
        @(negedge clk);
        bus.Addr_In = a;
        bus.Data_In = d;
        bus.WE      = 1'b1;
        @(negedge clk);
        bus.WE      = 1'b0;
        model[a]    = d;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        foreach (model[i]) model[i] = '0;

        // Reset held with a pending write; release coincides with a rising edge.
        rst_n          = 1'b0;
        bus.Addr_Out_A = 8'd3;
        bus.Addr_Out_B = 8'd7;
        bus.Addr_In    = 8'd3;
        bus.Data_In    = 16'h00AA;
        bus.WE         = 1'b1;
        #1;
        chk("rst_A", bus.Data_Out_A, 16'h0000);
        chk("rst_B", bus.Data_Out_B, 16'h0000);
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_edge_ignored", bus.Data_Out_A, 16'h0000);
        @(posedge clk);
        #1;
        chk("rel_next_edge", bus.Data_Out_A, 16'h00AA);
        @(negedge clk);
        bus.WE    = 1'b0;
        model[3]  = 16'h00AA;

        // WE low: nothing lands.
        bus.Addr_In = 8'd12; bus.Data_In = 16'd6;
        @(negedge clk);
        bus.Addr_In = 8'd13; bus.Data_In = 16'd7;
        @(negedge clk);
        rd_chk("we_gate", 8'd12, 8'd13);
        chk("we_gate_zero", bus.Data_Out_A | bus.Data_Out_B, 16'h0000);

        // Basic write / read.
        wr(8'd10, 16'd4);
        wr(8'd11, 16'd5);
        wr(8'd14, 16'd8);
        wr(8'd15, 16'd9);
        rd_chk("basic0", 8'd10, 8'd11);
        chk("basic0_lit", bus.Data_Out_A, 16'd4);
        rd_chk("basic1", 8'd14, 8'd15);
        chk("basic1_lit", bus.Data_Out_B, 16'd9);

        // Collision: old value before the edge, new value after.
        wr(8'd20, 16'h1111);
        @(negedge clk);
        bus.Addr_Out_A = 8'd20;
        bus.Addr_In    = 8'd20;
        bus.Data_In    = 16'h2222;
        bus.WE         = 1'b1;
        #1;
        chk("coll_pre", bus.Data_Out_A, 16'h1111);
        @(posedge clk);
        #1;
        chk("coll_post", bus.Data_Out_A, 16'h2222);
        @(negedge clk);
        bus.WE    = 1'b0;
        model[20] = 16'h2222;

        // Boundaries and both ports on one entry.
        wr(8'd255, 16'hFFFF);
        wr(8'd0,   16'h0001);
        rd_chk("same_255", 8'd255, 8'd255);
        chk("same_255_lit", bus.Data_Out_B, 16'hFFFF);
        rd_chk("entry0", 8'd0, 8'd255);
        chk("entry0_lit", bus.Data_Out_A, 16'h0001);

        // Random traffic; reads observed before each edge, model updated after.
        for (int it = 0; it < 400; it++) begin
            addr_t ra, rb, wa;
            data_t wd;
            logic  we;
            @(negedge clk);
            wa = addr_t'($urandom_range(0, DEPTH - 1));
            wd = data_t'($urandom);
            we = ($urandom_range(0, 3) != 0);
            ra = ($urandom_range(0, 3) == 0) ? wa : addr_t'($urandom_range(0, DEPTH - 1));
            rb = ($urandom_range(0, 7) == 0) ? ra : addr_t'($urandom_range(0, DEPTH - 1));
            bus.Addr_In = wa;
            bus.Data_In = wd;
            bus.WE      = we;
            rd_chk("rand", ra, rb);
            if (we) model[wa] = wd;
        end
        @(negedge clk);
        bus.WE = 1'b0;

        // Asynchronous reset mid-cycle clears without waiting for an edge.
        wr(8'd5, 16'hBEEF);
        rd_chk("pre_rst", 8'd5, 8'd0);
        #2;
        rst_n = 1'b0;
        foreach (model[i]) model[i] = '0;
        #1;
        chk("async_rst_A", bus.Data_Out_A, 16'h0000);
        rd_chk("async_rst_any", 8'd20, 8'd255);
        @(posedge clk);
        rst_n = 1'b1;
        wr(8'd99, 16'h5A5A);
        rd_chk("post_rst", 8'd99, 8'd5);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule
